// File: rtl/palette_pkg.sv
// Shared codes for the palette mux: colour component selectors and the
// four-phase slot schedule that splits RAM time between video and CPU.
package palette_pkg;

   typedef enum logic [1:0] {
      COMP_R      = 2'b00,
      COMP_G      = 2'b01,
      COMP_B      = 2'b10,
      COMP_BRIGHT = 2'b11
   } comp_e;

   localparam logic [1:0] SLOT_R   = 2'd0;
   localparam logic [1:0] SLOT_G   = 2'd1;
   localparam logic [1:0] SLOT_B   = 2'd2;
   localparam logic [1:0] SLOT_CPU = 2'd3;

   localparam logic [3:0] BRIGHT_FULL = 4'hF;

endpackage

// File: rtl/palette_spram.sv
// Single-port synchronous RAM with write enable and a registered read port.
// Contents are deliberately left uninitialised.
module palette_spram #(
   parameter int AW = 10,
   parameter int DW = 5
) (
   input  logic          CLK_32M,
   input  logic          we,
   input  logic [AW-1:0] addr,
   input  logic [DW-1:0] wdata,
   output logic [DW-1:0] rdata
);

   logic [DW-1:0] mem [0:(1<<AW)-1];

   always_ff @(posedge CLK_32M) begin
      if (we) begin
         mem[addr] <= wdata;
      end
      rdata <= mem[addr];
   end

endmodule

// File: rtl/palette_mux_n.sv
// Two-layer colour index mux with a time-shared palette RAM: slots 0..2 fetch
// R/G/B for the latched pixel, slot 3 serves one CPU access.
module palette_mux_n
   import palette_pkg::*;
#(
   parameter int CBITS = 5,
   parameter int IDX_W = 8
) (
   input  logic               CLK_32M,
   input  logic               RESET_N,
   input  logic               CE_PIX,
   input  logic [IDX_W-1:0]   CA,
   input  logic [IDX_W-1:0]   CB,
   input  logic               SELECT,
   input  logic               CBLK_N,
   input  logic               CPU_REQ,
   input  logic               CPU_WE,
   input  logic [IDX_W+1:0]   CPU_ADDR,
   input  logic [15:0]        CPU_DIN,
   output logic [15:0]        CPU_DOUT,
   output logic               CPU_ACK,
   output logic [CBITS-1:0]   RED,
   output logic [CBITS-1:0]   GRN,
   output logic [CBITS-1:0]   BLU
);

   localparam int AW = IDX_W + 2;

   // out = (c * (b + 1)) >> 4, written as c*b + c so no operand needs widening past 4 bits
   function automatic logic [CBITS-1:0] scale(input logic [CBITS-1:0] c,
                                              input logic [3:0]       b);
      logic [CBITS+4:0] prod;
      prod = {5'd0, c} * {{CBITS{1'b0}}, 1'b0, b} + {5'd0, c};
      return CBITS'(prod >> 4);
   endfunction

   logic [1:0]       slot_q;
   logic [3:0]       bright_q;
   logic [IDX_W-1:0] idx_p0;
   logic             blank_n_p0;
   logic [CBITS-1:0] stage_r_p1, stage_g_p1, stage_b_p1;
   logic [CBITS-1:0] stage_r_nxt, stage_g_nxt, stage_b_nxt;
   logic             vld_p1;
   comp_e            comp_p1;
   logic             ack_p1, rd_ram_p1, rd_bri_p1;
   logic [15:0]      dout_q, cpu_dout_c;

   logic             ram_we;
   logic [AW-1:0]    ram_addr;
   logic [CBITS-1:0] ram_wdata, ram_rdata;

   comp_e            cpu_comp;
   logic             cpu_exec, col_rd;
   logic             unused_din;

   assign unused_din = ^CPU_DIN;

   assign cpu_comp  = comp_e'(CPU_ADDR[AW-1 -: 2]);
   // ACK cycle is never slot 3, but the guard keeps a held request from firing twice
   assign cpu_exec  = RESET_N && CPU_REQ && (slot_q == SLOT_CPU) && !ack_p1;
   assign col_rd    = (slot_q != SLOT_CPU);
   assign ram_addr  = col_rd ? {slot_q, idx_p0} : CPU_ADDR;
   assign ram_we    = cpu_exec && CPU_WE && (cpu_comp != COMP_BRIGHT);
   assign ram_wdata = CPU_DIN[CBITS-1:0];

   palette_spram #(
      .AW (AW),
      .DW (CBITS)
   ) u_ram (
      .CLK_32M (CLK_32M),
      .we      (ram_we),
      .addr    (ram_addr),
      .wdata   (ram_wdata),
      .rdata   (ram_rdata)
   );

   // staging view including the read landing this cycle, so slot 2's blue is usable at CE
   always_comb begin
      stage_r_nxt = stage_r_p1;
      stage_g_nxt = stage_g_p1;
      stage_b_nxt = stage_b_p1;
      if (vld_p1) begin
         case (comp_p1)
            COMP_R:  stage_r_nxt = ram_rdata;
            COMP_G:  stage_g_nxt = ram_rdata;
            COMP_B:  stage_b_nxt = ram_rdata;
            default: ;
         endcase
      end
   end

   always_comb begin
      cpu_dout_c = dout_q;
      if (rd_ram_p1) begin
         cpu_dout_c = {{(16-CBITS){1'b0}}, ram_rdata};
      end else if (rd_bri_p1) begin
         cpu_dout_c = {12'h000, bright_q};
      end
   end

   assign CPU_DOUT = cpu_dout_c;
   assign CPU_ACK  = ack_p1;

   // p0: pixel latch on CE_PIX
   always_ff @(posedge CLK_32M) begin
      if (CE_PIX) begin
         idx_p0 <= SELECT ? CA : CB;
      end
   end

   // p1: staging capture, CPU response, output update
   always_ff @(posedge CLK_32M) begin
      if (!RESET_N) begin
         slot_q     <= SLOT_R;
         bright_q   <= BRIGHT_FULL;
         blank_n_p0 <= 1'b0;
         stage_r_p1 <= '0;
         stage_g_p1 <= '0;
         stage_b_p1 <= '0;
         vld_p1     <= 1'b0;
         comp_p1    <= COMP_R;
         ack_p1     <= 1'b0;
         rd_ram_p1  <= 1'b0;
         rd_bri_p1  <= 1'b0;
         dout_q     <= '0;
         RED        <= '0;
         GRN        <= '0;
         BLU        <= '0;
      end else begin
         slot_q     <= CE_PIX ? SLOT_R : slot_q + 2'd1;
         stage_r_p1 <= stage_r_nxt;
         stage_g_p1 <= stage_g_nxt;
         stage_b_p1 <= stage_b_nxt;
         vld_p1     <= col_rd;
         comp_p1    <= comp_e'(slot_q);
         ack_p1     <= cpu_exec;
         rd_ram_p1  <= cpu_exec && !CPU_WE && (cpu_comp != COMP_BRIGHT);
         rd_bri_p1  <= cpu_exec && !CPU_WE && (cpu_comp == COMP_BRIGHT);
         dout_q     <= cpu_dout_c;
         if (cpu_exec && CPU_WE && (cpu_comp == COMP_BRIGHT)) begin
            bright_q <= CPU_DIN[3:0];
         end
         if (CE_PIX) begin
            blank_n_p0 <= CBLK_N;
            RED <= blank_n_p0 ? scale(stage_r_nxt, bright_q) : '0;
            GRN <= blank_n_p0 ? scale(stage_g_nxt, bright_q) : '0;
            BLU <= blank_n_p0 ? scale(stage_b_nxt, bright_q) : '0;
         end
      end
   end

endmodule

// File: tb/tb_palette_mux_n.sv
// Bench for palette_mux_n: palette/brightness model checked every cycle plus
// directed literal expectations for the key scenarios.
module tb_palette_mux_n;

   localparam int CBITS = 5;
   localparam int IDX_W = 8;
   localparam int AW    = IDX_W + 2;
   localparam int NWORD = 1 << AW;

   logic             CLK_32M = 1'b0;
   logic             RESET_N, CE_PIX, SELECT, CBLK_N;
   logic             CPU_REQ, CPU_WE, CPU_ACK;
   logic [IDX_W-1:0] CA, CB;
   logic [AW-1:0]    CPU_ADDR;
   logic [15:0]      CPU_DIN, CPU_DOUT;
   logic [CBITS-1:0] RED, GRN, BLU;

   palette_mux_n #(.CBITS(CBITS), .IDX_W(IDX_W)) dut (
      .CLK_32M  (CLK_32M),
      .RESET_N  (RESET_N),
      .CE_PIX   (CE_PIX),
      .CA       (CA),
      .CB       (CB),
      .SELECT   (SELECT),
      .CBLK_N   (CBLK_N),
      .CPU_REQ  (CPU_REQ),
      .CPU_WE   (CPU_WE),
      .CPU_ADDR (CPU_ADDR),
      .CPU_DIN  (CPU_DIN),
      .CPU_DOUT (CPU_DOUT),
      .CPU_ACK  (CPU_ACK),
      .RED      (RED),
      .GRN      (GRN),
      .BLU      (BLU)
   );

   always #5 CLK_32M = ~CLK_32M;

   int checks = 0;
   int errors = 0;
   int cycle  = 0;
   bit ce_en  = 1'b1;
   bit chk_en = 1'b0;

   // model state
   int m_mem   [0:NWORD-1];
   bit m_known [0:NWORD-1];
   int m_bright, m_slot, m_pix_idx, m_red, m_grn, m_blu, m_dout;
   bit m_pix_bn, m_out_known, m_ack, m_dout_vld;

   function automatic int bscale(int c, int b);
      return (c * (b + 1)) / 16;
   endfunction

   task automatic check(string name, int act, int exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", name, act, exp, cycle);
      end
   endtask

   always @(posedge CLK_32M) begin : model
      bit exec;
      int a, idx;
      if (!RESET_N) begin
         m_slot = 0; m_bright = 15; m_pix_bn = 1'b0;
         m_red = 0; m_grn = 0; m_blu = 0; m_out_known = 1'b1;
         m_ack = 1'b0; m_dout_vld = 1'b0;
      end else begin
         a    = int'(CPU_ADDR);
         exec = CPU_REQ && (m_slot == 3) && !m_ack;
         if (CE_PIX) begin
            idx = m_pix_idx;
            if (!m_pix_bn) begin
               m_red = 0; m_grn = 0; m_blu = 0; m_out_known = 1'b1;
            end else if (m_known[idx] && m_known[idx + (1 << IDX_W)] && m_known[idx + (2 << IDX_W)]) begin
               m_red = bscale(m_mem[idx], m_bright);
               m_grn = bscale(m_mem[idx + (1 << IDX_W)], m_bright);
               m_blu = bscale(m_mem[idx + (2 << IDX_W)], m_bright);
               m_out_known = 1'b1;
            end else begin
               m_out_known = 1'b0;
            end
            m_pix_idx = SELECT ? int'(CA) : int'(CB);
            m_pix_bn  = CBLK_N;
         end
         m_dout_vld = 1'b0;
         if (exec) begin
            if ((a >> IDX_W) == 3) begin
               if (CPU_WE) m_bright = int'(CPU_DIN) & 15;
               else begin m_dout = m_bright; m_dout_vld = 1'b1; end
            end else if (CPU_WE) begin
               m_mem[a] = int'(CPU_DIN) & ((1 << CBITS) - 1);
               m_known[a] = 1'b1;
            end else begin
               m_dout = m_mem[a]; m_dout_vld = m_known[a];
            end
         end
         m_ack  = exec;
         m_slot = CE_PIX ? 0 : (m_slot + 1) % 4;
      end
   end

   always @(negedge CLK_32M) begin
      if (chk_en) begin
         if (m_out_known) begin
            check("model_red", int'(RED), m_red);
            check("model_grn", int'(GRN), m_grn);
            check("model_blu", int'(BLU), m_blu);
         end
         check("model_ack", int'(CPU_ACK), int'(m_ack));
         if (m_ack && m_dout_vld) check("model_dout", int'(CPU_DOUT), m_dout);
      end
   end

   task automatic step();
      @(posedge CLK_32M);
      cycle++;
      @(negedge CLK_32M);
      CE_PIX = ce_en && (m_slot == 3);
   endtask

   task automatic cpu_xfer(input bit we, input int addr, input int din,
                           output int dout, output int ack_cyc);
      bit got;
      got = 1'b0;
      CPU_REQ = 1'b1; CPU_WE = we; CPU_ADDR = addr[AW-1:0]; CPU_DIN = din[15:0];
      for (int n = 0; n < 24 && !got; n++) begin
         step();
         if (CPU_ACK) got = 1'b1;
      end
      checks++;
      if (!got) begin
         errors++;
         $display("FAIL cpu_ack_timeout: addr 0x%0h got no ACK, required ACK within 24 cycles", addr);
      end
      dout = int'(CPU_DOUT);
      ack_cyc = cycle;
      CPU_REQ = 1'b0; CPU_WE = 1'b0;
   endtask

   task automatic show(input bit sel, input int ca, input int cb, input bit bn);
      SELECT = sel; CA = ca[IDX_W-1:0]; CB = cb[IDX_W-1:0]; CBLK_N = bn;
      repeat (4) step();
   endtask

   task automatic sync_slot0();
      for (int n = 0; n < 8 && m_slot != 0; n++) step();
   endtask

   task automatic check_rgb(string name, int r, int g, int b);
      check({name, "_red"}, int'(RED), r);
      check({name, "_grn"}, int'(GRN), g);
      check({name, "_blu"}, int'(BLU), b);
   endtask

   initial begin
      #2_000_000;
      $display("FAIL watchdog: simulation did not finish, required finish before 2 ms");
      $fatal(1);
   end

   initial begin
      int d, c1, c2, c3;
      RESET_N = 1'b0; CE_PIX = 1'b0; SELECT = 1'b0; CA = '0; CB = '0; CBLK_N = 1'b0;
      CPU_REQ = 1'b0; CPU_WE = 1'b0; CPU_ADDR = '0; CPU_DIN = '0;
      repeat (3) step();
      check_rgb("reset", 0, 0, 0);
      check("reset_ack", int'(CPU_ACK), 0);
      check("reset_dout", int'(CPU_DOUT), 0);
      chk_en  = 1'b1;
      RESET_N = 1'b1;

      // palette entry 0x12; junk upper DIN bits must be ignored
      cpu_xfer(1'b1, 'h012, 'hA5FF, d, c1);
      cpu_xfer(1'b1, 'h112, 'h0010, d, c1);
      cpu_xfer(1'b1, 'h212, 'hFFE1, d, c1);

      show(1'b1, 'h12, 'h33, 1'b1);
      show(1'b0, 'h44, 'h12, 1'b0);
      check_rgb("pix_basic", 'h1F, 'h10, 'h01);
      show(1'b0, 'h44, 'h12, 1'b1);
      check_rgb("pix_blank", 0, 0, 0);
      show(1'b0, 'h44, 'h12, 1'b1);
      check_rgb("pix_restore", 'h1F, 'h10, 'h01);

      // brightness 7, index bits ignored for component 11
      cpu_xfer(1'b1, 'h3FF, 'hFFF7, d, c1);
      cpu_xfer(1'b0, 'h300, 0, d, c1);
      check("bright_read", d, 'h0007);
      show(1'b1, 'h12, 'h00, 1'b1);
      show(1'b1, 'h12, 'h00, 1'b1);
      check_rgb("pix_bright7", 'h0F, 'h08, 'h00);

      // read issued in slot 0 executes in slot 3, ACK the next cycle only
      sync_slot0();
      CPU_REQ = 1'b1; CPU_WE = 1'b0; CPU_ADDR = 'h112;
      for (int n = 1; n <= 5; n++) begin
         step();
         if (n < 4) check("ack_early", int'(CPU_ACK), 0);
         if (n == 4) begin
            check("ack_slot3", int'(CPU_ACK), 1);
            check("ack_dout", int'(CPU_DOUT), 'h0010);
            CPU_REQ = 1'b0;
         end
         if (n == 5) check("ack_single", int'(CPU_ACK), 0);
      end

      // pixel strobe stopped: back-to-back writes, one ACK per 4 clocks
      ce_en = 1'b0;
      cpu_xfer(1'b1, 'h020, 'h000A, d, c1);
      cpu_xfer(1'b1, 'h120, 'h0015, d, c2);
      cpu_xfer(1'b1, 'h220, 'h001E, d, c3);
      check("b2b_gap1", c2 - c1, 4);
      check("b2b_gap2", c3 - c2, 4);
      check("dout_hold", int'(CPU_DOUT), 'h0010);
      cpu_xfer(1'b0, 'h020, 0, d, c1); check("b2b_rd_r", d, 'h0A);
      cpu_xfer(1'b0, 'h120, 0, d, c1); check("b2b_rd_g", d, 'h15);
      cpu_xfer(1'b0, 'h220, 0, d, c1); check("b2b_rd_b", d, 'h1E);
      cpu_xfer(1'b1, 'h300, 'h000F, d, c1);
      ce_en = 1'b1;
      show(1'b1, 'h20, 'h00, 1'b1);
      show(1'b1, 'h12, 'h00, 1'b1);
      check_rgb("pix_idx20", 'h0A, 'h15, 'h1E);

      // reset while a write is pending in slot 2
      cpu_xfer(1'b1, 'h300, 'h0009, d, c1);
      sync_slot0();
      CPU_REQ = 1'b1; CPU_WE = 1'b1; CPU_ADDR = 'h012; CPU_DIN = 'h0005;
      step();
      step();
      RESET_N = 1'b0;
      for (int n = 0; n < 3; n++) begin
         step();
         check("rst_noack", int'(CPU_ACK), 0);
      end
      CPU_REQ = 1'b0; CPU_WE = 1'b0;
      check_rgb("rst_pending", 0, 0, 0);
      check("rst_pending_dout", int'(CPU_DOUT), 0);
      RESET_N = 1'b1;
      for (int n = 0; n < 6; n++) begin
         step();
         check("rst_noack_after", int'(CPU_ACK), 0);
      end
      cpu_xfer(1'b0, 'h012, 0, d, c1); check("rst_ram_kept", d, 'h1F);
      cpu_xfer(1'b0, 'h300, 0, d, c1); check("rst_bright", d, 'h000F);
      show(1'b1, 'h12, 'h00, 1'b1);
      show(1'b1, 'h12, 'h00, 1'b1);
      check_rgb("pix_after_rst", 'h1F, 'h10, 'h01);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
